// File: rtl/tower_slot_manager_if.sv
// Spawn/hit request bus between the game controller and the tower slot manager.
// The controller (master) raises one-cycle requests; the manager (slave)
// answers spawn requests with a one-cycle ack or reject pulse.
interface tower_slot_manager_if #(
    parameter int NUM_SLOTS = 4
) ();
    logic                         spawnReq;
    logic [10:0]                  spawnX;
    logic [10:0]                  spawnY;
    logic                         spawnAck;
    logic                         spawnReject;
    logic                         hitReq;
    logic [$clog2(NUM_SLOTS)-1:0] hitSlot;

    modport master (
        output spawnReq, spawnX, spawnY, hitReq, hitSlot,
        input  spawnAck, spawnReject
    );

    modport slave (
        input  spawnReq, spawnX, spawnY, hitReq, hitSlot,
        output spawnAck, spawnReject
    );
endinterface

// File: rtl/tower_slot_manager.sv
// Tower slot manager: a small pool of on-screen towers. Each slot is EMPTY,
// ALIVE or DYING (blinking for BLINK_FRAMES frames before it frees up).
// Also performs the per-pixel lookup that tells the drawing logic which
// tower (lowest index wins) covers the current scan pixel.
module tower_slot_manager #(
    parameter int NUM_SLOTS       = 4,
    parameter int OBJECT_WIDTH_X  = 28,
    parameter int OBJECT_HEIGHT_Y = 58,
    parameter int BLINK_FRAMES    = 8
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic [10:0]                  pixelX,
    input  logic [10:0]                  pixelY,
    input  logic                         startOfFrame,
    tower_slot_manager_if.slave          bus,
    output logic [10:0]                  offsetX,
    output logic [10:0]                  offsetY,
    output logic                         InsideRectangle,
    output logic [$clog2(NUM_SLOTS):0]   activeCount,
    output logic                         full
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int CW = $clog2(BLINK_FRAMES) + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ALIVE = 2'd1,
        DYING = 2'd2
    } slot_state_t;

    slot_state_t       state     [NUM_SLOTS];
    logic [10:0]       top_x     [NUM_SLOTS];
    logic [10:0]       top_y     [NUM_SLOTS];
    logic [CW-1:0]     cnt       [NUM_SLOTS];

    slot_state_t       nxt_state [NUM_SLOTS];
    logic [10:0]       nxt_x     [NUM_SLOTS];
    logic [10:0]       nxt_y     [NUM_SLOTS];
    logic [CW-1:0]     nxt_cnt   [NUM_SLOTS];
    logic [SW:0]       nxt_count;
    logic              spawn_found;
    logic [SW-1:0]     spawn_idx;

    logic              look_hit;
    logic [10:0]       look_ox;
    logic [10:0]       look_oy;

    // Next slot state: frame countdown, hit, and spawn into lowest EMPTY slot.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update so no latch is inferred.
        nxt_state   = state;
        nxt_x       = top_x;
        nxt_y       = top_y;
        nxt_cnt     = cnt;
        nxt_count   = '0;
        spawn_found = 1'b0;
        spawn_idx   = '0;

        // Scan high to low so the lowest EMPTY index is the one left standing.
        // Uses the current state, so a slot freed this cycle is not eligible.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (state[i] == EMPTY) begin
                spawn_found = 1'b1;
                spawn_idx   = SW'(i);
            end
        end

        // Each slot is touched by at most one of these: countdown only hits
        // DYING slots, a hit only ALIVE ones, a spawn only EMPTY ones.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (state[i] == DYING && startOfFrame) begin
                if (cnt[i] == CW'(1)) begin
                    nxt_state[i] = EMPTY;
                    nxt_cnt[i]   = '0;
                end else begin
                    nxt_cnt[i]   = cnt[i] - CW'(1);
                end
            end
            // An out-of-range hitSlot never matches any index and is ignored.
            if (bus.hitReq && bus.hitSlot == SW'(i) && state[i] == ALIVE) begin
                nxt_state[i] = DYING;
                nxt_cnt[i]   = CW'(BLINK_FRAMES);
            end
            if (bus.spawnReq && spawn_found && spawn_idx == SW'(i)) begin
                nxt_state[i] = ALIVE;
                nxt_x[i]     = bus.spawnX;
                nxt_y[i]     = bus.spawnY;
            end
        end

        for (int i = 0; i < NUM_SLOTS; i++) begin
            nxt_count = nxt_count + {{SW{1'b0}}, (nxt_state[i] != EMPTY)};
        end
    end

    // Pixel lookup: visible slot covering the pixel, lowest index has priority.
    always_comb begin
        logic [11:0] px, py, lx, ly;
        logic        vis;
        look_hit = 1'b0;
        look_ox  = '0;
        look_oy  = '0;
        px       = {1'b0, pixelX};
        py       = {1'b0, pixelY};
        lx       = '0;
        ly       = '0;
        vis      = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            lx  = {1'b0, top_x[i]};
            ly  = {1'b0, top_y[i]};
            vis = (state[i] == ALIVE) || (state[i] == DYING && cnt[i][0]);
            // 12-bit sums keep towers near the right/bottom edge from wrapping.
            if (vis && px >= lx && px < lx + 12'(OBJECT_WIDTH_X)
                    && py >= ly && py < ly + 12'(OBJECT_HEIGHT_Y)) begin
                look_hit = 1'b1;
                look_ox  = pixelX - top_x[i];
                look_oy  = pixelY - top_y[i];
            end
        end
    end

    // Slot storage update.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (resetN) begin
            // NOTE: the slot table is a handful of flops that must come up EMPTY, so it is reset explicitly.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state[i] <= EMPTY;
                top_x[i] <= '0;
                top_y[i] <= '0;
                cnt[i]   <= '0;
            end
        end else begin
            state <= nxt_state;
            top_x <= nxt_x;
            top_y <= nxt_y;
            cnt   <= nxt_cnt;
        end
    end

    // Registered handshake pulses, lookup results and occupancy status.
    always_ff @(posedge clk) begin
        if (resetN) begin
            bus.spawnAck    <= 1'b0;
            bus.spawnReject <= 1'b0;
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
            activeCount     <= '0;
            full            <= 1'b0;
        end else begin
            bus.spawnAck    <= bus.spawnReq && spawn_found;
            bus.spawnReject <= bus.spawnReq && !spawn_found;
            InsideRectangle <= look_hit;
            offsetX         <= look_ox;
            offsetY         <= look_oy;
            activeCount     <= nxt_count;
            full            <= (nxt_count == (SW + 1)'(NUM_SLOTS));
        end
    end

endmodule

// File: tb/tb_tower_slot_manager.sv
// Directed testbench for tower_slot_manager (NUM_SLOTS = 4, BLINK_FRAMES = 8).
module tb_tower_slot_manager;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame;
    logic [10:0] offsetX, offsetY;
    logic        InsideRectangle;
    logic [2:0]  activeCount;
    logic        full;

    int n_cmp = 0;
    int n_bad = 0;

    tower_slot_manager_if #(.NUM_SLOTS(4)) bus ();

    tower_slot_manager #(
        .NUM_SLOTS(4), .OBJECT_WIDTH_X(28), .OBJECT_HEIGHT_Y(58), .BLINK_FRAMES(8)
    ) dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .bus(bus), .offsetX(offsetX), .offsetY(offsetY),
        .InsideRectangle(InsideRectangle), .activeCount(activeCount), .full(full)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.spawnReq = 1'b0; bus.spawnX = '0; bus.spawnY = '0;
        bus.hitReq = 1'b0; bus.hitSlot = '0; startOfFrame = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b1; pixelX = 11'd0; pixelY = 11'd0; idle_inputs();
        tick(); tick();
        n_cmp++; if (bus.spawnAck !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", bus.spawnAck); end
        n_cmp++; if (bus.spawnReject !== 1'b0) begin n_bad++; $display("FAIL reset_reject: got %b want 0", bus.spawnReject); end
        n_cmp++; if (InsideRectangle !== 1'b0) begin n_bad++; $display("FAIL reset_inside: got %b want 0", InsideRectangle); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (activeCount !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", activeCount); end
        n_cmp++; if (offsetX !== 11'd0 || offsetY !== 11'd0) begin n_bad++; $display("FAIL reset_offsets: got %0d,%0d want 0,0", offsetX, offsetY); end
        resetN = 1'b0;
        tick();
    endtask

    // Single spawn at (100,200) and pixel lookup around its edges.
    task automatic test_spawn_lookup();
        bus.spawnReq = 1'b1; bus.spawnX = 11'd100; bus.spawnY = 11'd200;
        tick();
        n_cmp++; if (bus.spawnAck !== 1'b1 || bus.spawnReject !== 1'b0) begin n_bad++; $display("FAIL spawn0_ack: got ack=%b rej=%b want 1,0", bus.spawnAck, bus.spawnReject); end
        n_cmp++; if (activeCount !== 3'd1 || full !== 1'b0) begin n_bad++; $display("FAIL spawn0_count: got %0d full=%b want 1,0", activeCount, full); end
        bus.spawnReq = 1'b0; pixelX = 11'd113; pixelY = 11'd229;
        tick();
        n_cmp++; if (bus.spawnAck !== 1'b0) begin n_bad++; $display("FAIL spawn0_ack_pulse: got %b want 0", bus.spawnAck); end
        n_cmp++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd13 || offsetY !== 11'd29) begin n_bad++; $display("FAIL look_inside: got %b %0d,%0d want 1 13,29", InsideRectangle, offsetX, offsetY); end
        pixelX = 11'd128; pixelY = 11'd229;
        tick();
        n_cmp++; if (InsideRectangle !== 1'b0 || offsetX !== 11'd0 || offsetY !== 11'd0) begin n_bad++; $display("FAIL look_right_edge: got %b %0d,%0d want 0 0,0", InsideRectangle, offsetX, offsetY); end
        pixelX = 11'd127; pixelY = 11'd257;
        tick();
        n_cmp++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd27 || offsetY !== 11'd57) begin n_bad++; $display("FAIL look_corner: got %b %0d,%0d want 1 27,57", InsideRectangle, offsetX, offsetY); end
        pixelX = 11'd99; pixelY = 11'd258;
        tick();
        n_cmp++; if (InsideRectangle !== 1'b0) begin n_bad++; $display("FAIL look_outside: got %b want 0", InsideRectangle); end
    endtask

    // Fill remaining slots, then one spawn too many.
    task automatic test_fill();
        logic [10:0] xs [3];
        logic [10:0] ys [3];
        xs[0] = 11'd300; ys[0] = 11'd300;
        xs[1] = 11'd110; ys[1] = 11'd210;
        xs[2] = 11'd500; ys[2] = 11'd500;
        for (int i = 0; i < 3; i++) begin
            bus.spawnReq = 1'b1; bus.spawnX = xs[i]; bus.spawnY = ys[i];
            tick();
            n_cmp++; if (bus.spawnAck !== 1'b1 || activeCount !== 3'(i + 2) || full !== (i == 2)) begin n_bad++; $display("FAIL fill_%0d: got ack=%b cnt=%0d full=%b want 1,%0d,%0d", i, bus.spawnAck, activeCount, full, i + 2, i == 2); end
        end
        bus.spawnX = 11'd900; bus.spawnY = 11'd900;
        tick();
        n_cmp++; if (bus.spawnReject !== 1'b1 || bus.spawnAck !== 1'b0) begin n_bad++; $display("FAIL fill_reject: got ack=%b rej=%b want 0,1", bus.spawnAck, bus.spawnReject); end
        n_cmp++; if (activeCount !== 3'd4 || full !== 1'b1) begin n_bad++; $display("FAIL fill_status: got %0d full=%b want 4,1", activeCount, full); end
        bus.spawnReq = 1'b0; pixelX = 11'd505; pixelY = 11'd505;
        tick();
        n_cmp++; if (bus.spawnReject !== 1'b0) begin n_bad++; $display("FAIL fill_reject_pulse: got %b want 0", bus.spawnReject); end
        n_cmp++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd5 || offsetY !== 11'd5) begin n_bad++; $display("FAIL slot3_pos: got %b %0d,%0d want 1 5,5", InsideRectangle, offsetX, offsetY); end
        pixelX = 11'd115; pixelY = 11'd215;
        tick();
        n_cmp++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd15 || offsetY !== 11'd15) begin n_bad++; $display("FAIL overlap_prio: got %b %0d,%0d want 1 15,15", InsideRectangle, offsetX, offsetY); end
    endtask

    // Same-cycle hit on slot 0 and spawn while full: reject, slot 0 not reused.
    task automatic test_hit_spawn_same_cycle();
        bus.hitReq = 1'b1; bus.hitSlot = 2'd0;
        bus.spawnReq = 1'b1; bus.spawnX = 11'd900; bus.spawnY = 11'd900;
        tick();
        n_cmp++; if (bus.spawnReject !== 1'b1 || bus.spawnAck !== 1'b0) begin n_bad++; $display("FAIL same_cycle_reject: got ack=%b rej=%b want 0,1", bus.spawnAck, bus.spawnReject); end
        n_cmp++; if (activeCount !== 3'd4 || full !== 1'b1) begin n_bad++; $display("FAIL same_cycle_status: got %0d full=%b want 4,1", activeCount, full); end
        idle_inputs(); pixelX = 11'd115; pixelY = 11'd215;
        tick();
        n_cmp++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd5 || offsetY !== 11'd5) begin n_bad++; $display("FAIL dying_hidden_overlap: got %b %0d,%0d want 1 5,5", InsideRectangle, offsetX, offsetY); end
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        n_cmp++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd15 || offsetY !== 11'd15) begin n_bad++; $display("FAIL dying_visible_overlap: got %b %0d,%0d want 1 15,15", InsideRectangle, offsetX, offsetY); end
    endtask

    // Hit slot 1 and run 8 frames; slot 0 (counter 7) also expires on frame 7.
    task automatic test_blink();
        logic exp_in;
        int   exp_cnt;
        bus.hitReq = 1'b1; bus.hitSlot = 2'd1;
        tick();
        idle_inputs(); pixelX = 11'd300; pixelY = 11'd300;
        for (int j = 1; j <= 8; j++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
            exp_in  = (j < 8) && (((8 - j) % 2) == 1);
            exp_cnt = 4 - ((j >= 7) ? 1 : 0) - ((j >= 8) ? 1 : 0);
            n_cmp++; if (InsideRectangle !== exp_in) begin n_bad++; $display("FAIL blink_vis_%0d: got %b want %b", j, InsideRectangle, exp_in); end
            n_cmp++; if (activeCount !== 3'(exp_cnt)) begin n_bad++; $display("FAIL blink_count_%0d: got %0d want %0d", j, activeCount, exp_cnt); end
            if (j == 3) begin
                // A hit on an already DYING slot must not reload its counter.
                bus.hitReq = 1'b1; bus.hitSlot = 2'd1;
                tick();
                bus.hitReq = 1'b0;
            end
        end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL blink_full: got %b want 0", full); end
    endtask

    // Freed slot 0 is reused first; hit on an EMPTY slot is ignored.
    task automatic test_respawn();
        bus.spawnReq = 1'b1; bus.spawnX = 11'd700; bus.spawnY = 11'd700;
        tick();
        n_cmp++; if (bus.spawnAck !== 1'b1 || activeCount !== 3'd3) begin n_bad++; $display("FAIL respawn: got ack=%b cnt=%0d want 1,3", bus.spawnAck, activeCount); end
        idle_inputs(); bus.hitReq = 1'b1; bus.hitSlot = 2'd1;
        tick();
        n_cmp++; if (activeCount !== 3'd3) begin n_bad++; $display("FAIL hit_empty_ignored: got %0d want 3", activeCount); end
        bus.hitSlot = 2'd0; pixelX = 11'd700; pixelY = 11'd700;
        tick();
        idle_inputs();
        tick();
        n_cmp++; if (InsideRectangle !== 1'b0 || activeCount !== 3'd3) begin n_bad++; $display("FAIL respawn_slot0: got %b cnt=%0d want 0,3", InsideRectangle, activeCount); end
    endtask

    // Reset in the middle of a blink, together with a spawn request.
    task automatic test_reset_mid_blink();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        n_cmp++; if (InsideRectangle !== 1'b1) begin n_bad++; $display("FAIL pre_reset_visible: got %b want 1", InsideRectangle); end
        resetN = 1'b1; bus.spawnReq = 1'b1; bus.spawnX = 11'd10; bus.spawnY = 11'd10;
        tick();
        n_cmp++; if (InsideRectangle !== 1'b0 || bus.spawnAck !== 1'b0 || bus.spawnReject !== 1'b0 || full !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags: got in=%b ack=%b rej=%b full=%b want 0", InsideRectangle, bus.spawnAck, bus.spawnReject, full); end
        n_cmp++; if (activeCount !== 3'd0 || offsetX !== 11'd0 || offsetY !== 11'd0) begin n_bad++; $display("FAIL mid_reset_values: got cnt=%0d off=%0d,%0d want 0", activeCount, offsetX, offsetY); end
        idle_inputs();
        tick();
        resetN = 1'b0;
        tick();
        n_cmp++; if (bus.spawnAck !== 1'b0 || bus.spawnReject !== 1'b0 || activeCount !== 3'd0) begin n_bad++; $display("FAIL post_reset_quiet: got ack=%b rej=%b cnt=%0d want 0,0,0", bus.spawnAck, bus.spawnReject, activeCount); end
        bus.spawnReq = 1'b1; bus.spawnX = 11'd50; bus.spawnY = 11'd50;
        tick();
        n_cmp++; if (bus.spawnAck !== 1'b1 || activeCount !== 3'd1) begin n_bad++; $display("FAIL post_reset_spawn: got ack=%b cnt=%0d want 1,1", bus.spawnAck, activeCount); end
        idle_inputs(); bus.hitReq = 1'b1; bus.hitSlot = 2'd0; pixelX = 11'd50; pixelY = 11'd50;
        tick();
        idle_inputs();
        tick();
        n_cmp++; if (InsideRectangle !== 1'b0) begin n_bad++; $display("FAIL post_reset_slot0_hidden: got %b want 0", InsideRectangle); end
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        n_cmp++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd0 || offsetY !== 11'd0) begin n_bad++; $display("FAIL post_reset_slot0_blink: got %b %0d,%0d want 1 0,0", InsideRectangle, offsetX, offsetY); end
    endtask

    initial begin
        test_reset();
        test_spawn_lookup();
        test_fill();
        test_hit_spawn_same_cycle();
        test_blink();
        test_respawn();
        test_reset_mid_blink();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
